// File: rtl/mtimer_pkg.sv
// Shared definitions for the machine timer: register offsets, CTRL field
// positions, interrupt bus layout and the bus response state encoding.
package mtimer_pkg;

  localparam int unsigned INT_BUS   = 8;
  localparam int unsigned INT_TIMER = 0;

  localparam logic [4:0] MTIMER_CTRL     = 5'h00;
  localparam logic [4:0] MTIMER_MTIME_LO = 5'h04;
  localparam logic [4:0] MTIMER_MTIME_HI = 5'h08;
  localparam logic [4:0] MTIMER_CMP_LO   = 5'h0C;
  localparam logic [4:0] MTIMER_CMP_HI   = 5'h10;

  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_IE_BIT    = 1;
  localparam int unsigned CTRL_PEND_BIT  = 2;
  localparam int unsigned CTRL_PRESC_LSB = 8;
  localparam int unsigned CTRL_PRESC_MSB = 15;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

  typedef struct packed {
    logic [7:0] presc;
    logic       pend;
    logic       ie;
    logic       en;
  } ctrl_t;

  // CTRL as seen on the bus; unused bits read as zero.
  function automatic logic [31:0] ctrl_pack(input ctrl_t c);
    logic [31:0] w;
    w = '0;
    w[CTRL_EN_BIT]                   = c.en;
    w[CTRL_IE_BIT]                   = c.ie;
    w[CTRL_PEND_BIT]                 = c.pend;
    w[CTRL_PRESC_MSB:CTRL_PRESC_LSB] = c.presc;
    return w;
  endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Prescaler for mtime: issues a one-cycle tick every PRESC+1 enabled cycles.
// A restart pulse (any PRESC write) re-arms the count from zero.
module mtimer_prescaler (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [7:0] presc_i,
  input  logic       restart_i,
  output logic       tick_o
);

  logic [7:0] pcnt_q, pcnt_d;

  // Next count and tick; a restart cycle never ticks.
  always_comb begin
    pcnt_d = pcnt_q;
    tick_o = 1'b0;
    if (!en_i || restart_i) begin
      pcnt_d = '0;
    end else if (pcnt_q == presc_i) begin
      pcnt_d = '0;
      tick_o = 1'b1;
    end else begin
      pcnt_d = pcnt_q + 8'd1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) pcnt_q <= '0;
    else      pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/mtimer.sv
// Memory-mapped machine timer: 64-bit mtime, 64-bit mtimecmp, sticky pending
// bit and a single-cycle registered bus response.
module mtimer
  import mtimer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        data_i,
  output logic [31:0]        data_o,
  output logic               ack_o,
  output logic [INT_BUS-1:0] int_flag_o
);

  ctrl_t       ctrl_q, ctrl_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;
  logic [31:0] rdata_q, rdata_d;
  bus_state_e  state_q, state_d;

  logic [4:0]  off;
  logic        sel, wr, rd;
  logic        wr_ctrl, wr_lo, wr_hi, wr_cmp_lo, wr_cmp_hi, rd_lo;
  logic        tick, hit;
  logic [31:0] rmux;
  logic        unused_addr_bits;

  assign off              = addr_i[4:0];
  assign sel              = req_i && (addr_i[31:8] == BASE_ADDR[31:8]);
  assign wr               = sel && we_i;
  assign rd               = sel && !we_i;
  assign wr_ctrl          = wr && (off == MTIMER_CTRL);
  assign wr_lo            = wr && (off == MTIMER_MTIME_LO);
  assign wr_hi            = wr && (off == MTIMER_MTIME_HI);
  assign wr_cmp_lo        = wr && (off == MTIMER_CMP_LO);
  assign wr_cmp_hi        = wr && (off == MTIMER_CMP_HI);
  assign rd_lo            = rd && (off == MTIMER_MTIME_LO);
  assign hit              = (mtime_q >= cmp_q);
  assign unused_addr_bits = ^addr_i[7:5];

  mtimer_prescaler u_presc (
    .clk       (clk),
    .rst       (rst),
    .en_i      (ctrl_q.en),
    .presc_i   (ctrl_q.presc),
    .restart_i (wr_ctrl),
    .tick_o    (tick)
  );

  // Register file next state: software writes beat ticks; a compare hit beats W1C.
  always_comb begin
    ctrl_d      = ctrl_q;
    mtime_d     = mtime_q;
    cmp_d       = cmp_q;
    hi_shadow_d = hi_shadow_q;
    if (wr_ctrl) begin
      ctrl_d.en    = data_i[CTRL_EN_BIT];
      ctrl_d.ie    = data_i[CTRL_IE_BIT];
      ctrl_d.presc = data_i[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
    end
    if (hit)                                 ctrl_d.pend = 1'b1;
    else if (wr_ctrl && data_i[CTRL_PEND_BIT]) ctrl_d.pend = 1'b0;
    if (wr_lo)      mtime_d[31:0]  = data_i;
    else if (wr_hi) mtime_d[63:32] = data_i;
    else if (tick)  mtime_d        = mtime_q + 64'd1;
    if (wr_cmp_lo)  cmp_d[31:0]    = data_i;
    if (wr_cmp_hi)  cmp_d[63:32]   = data_i;
    if (rd_lo)      hi_shadow_d    = mtime_q[63:32];
  end

  // Read mux; unmapped offsets read as zero.
  always_comb begin
    rmux = '0;
    case (off)
      MTIMER_CTRL:     rmux = ctrl_pack(ctrl_q);
      MTIMER_MTIME_LO: rmux = mtime_q[31:0];
      MTIMER_MTIME_HI: rmux = hi_shadow_q;
      MTIMER_CMP_LO:   rmux = cmp_q[31:0];
      MTIMER_CMP_HI:   rmux = cmp_q[63:32];
      default:         rmux = '0;
    endcase
  end

  // Bus response FSM next state: every hit request is acknowledged next cycle.
  always_comb begin
    state_d = BUS_IDLE;
    rdata_d = '0;
    if (sel) begin
      state_d = BUS_ACK;
      if (rd) rdata_d = rmux;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q      <= '0;
      mtime_q     <= '0;
      cmp_q       <= '1;
      hi_shadow_q <= '0;
      rdata_q     <= '0;
      state_q     <= BUS_IDLE;
    end else begin
      ctrl_q      <= ctrl_d;
      mtime_q     <= mtime_d;
      cmp_q       <= cmp_d;
      hi_shadow_q <= hi_shadow_d;
      rdata_q     <= rdata_d;
      state_q     <= state_d;
    end
  end

  // Outputs: registered response, interrupt gated directly by IE.
  always_comb begin
    ack_o                 = (state_q == BUS_ACK);
    data_o                = rdata_q;
    int_flag_o            = '0;
    int_flag_o[INT_TIMER] = ctrl_q.pend & ctrl_q.ie;
  end

endmodule

// File: tb/tb_mtimer.sv
// Directed self-checking bench for mtimer.
module tb_mtimer;
  import mtimer_pkg::*;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, we_i;
  logic [31:0] addr_i, data_i, data_o;
  logic        ack_o;
  logic [7:0]  int_flag_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] scratch;

  always #5 clk = ~clk;

  mtimer #(.BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .ack_o      (ack_o),
    .int_flag_o (int_flag_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle bus transfer; entered and left 1ns after a rising edge.
  task automatic xfer(input logic we, input logic [4:0] off, input logic [31:0] wd,
                      output logic [31:0] rdat);
    req_i  = 1'b1;
    we_i   = we;
    addr_i = BASE | {27'd0, off};
    data_i = wd;
    @(posedge clk);
    #1;
    req_i  = 1'b0;
    we_i   = 1'b0;
    check_eq("ack", {63'd0, ack_o}, 64'd1);
    rdat = data_o;
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] wd);
    logic [31:0] d;
    xfer(1'b1, off, wd, d);
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] off, input logic [31:0] exp);
    logic [31:0] d;
    xfer(1'b0, off, 32'd0, d);
    check_eq(tag, {32'd0, d}, {32'd0, exp});
  endtask

  initial begin
    rst = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ack", {63'd0, ack_o}, 64'd0);
    check_eq("rst_data", {32'd0, data_o}, 64'd0);
    check_eq("rst_int", {56'd0, int_flag_o}, 64'd0);
    rst = 1'b1;

    // Reset values of every register
    rd_chk("r_ctrl", MTIMER_CTRL, 32'd0);
    rd_chk("r_lo", MTIMER_MTIME_LO, 32'd0);
    rd_chk("r_hi", MTIMER_MTIME_HI, 32'd0);
    rd_chk("r_cmplo", MTIMER_CMP_LO, 32'hFFFF_FFFF);
    rd_chk("r_cmphi", MTIMER_CMP_HI, 32'hFFFF_FFFF);
    idle(1);
    check_eq("ack_1cyc", {63'd0, ack_o}, 64'd0);
    check_eq("data_idle", {32'd0, data_o}, 64'd0);
    check_eq("r_int", {56'd0, int_flag_o}, 64'd0);

    // Prescaler 3: ticks every 4 cycles
    wr(MTIMER_CTRL, 32'h0000_0301);
    idle(40);
    rd_chk("p3_40", MTIMER_MTIME_LO, 32'd10);
    idle(2);
    rd_chk("p3_pre", MTIMER_MTIME_LO, 32'd10);
    rd_chk("p3_post", MTIMER_MTIME_LO, 32'd11);
    wr(MTIMER_CTRL, 32'd0);
    rd_chk("p3_hold", MTIMER_MTIME_LO, 32'd11);

    // Compare, pending, W1C vs hit, IE gating
    wr(MTIMER_MTIME_LO, 32'd0);
    wr(MTIMER_CMP_HI, 32'd0);
    wr(MTIMER_CMP_LO, 32'd5);
    wr(MTIMER_CTRL, 32'h0000_0003);
    idle(5);
    check_eq("int_at5", {56'd0, int_flag_o}, 64'd0);
    idle(1);
    check_eq("int_after5", {56'd0, int_flag_o}, 64'd1);
    rd_chk("pend_set", MTIMER_CTRL, 32'h7);
    wr(MTIMER_CTRL, 32'h7);
    rd_chk("w1c_hit", MTIMER_CTRL, 32'h7);
    wr(MTIMER_CMP_HI, 32'd1);
    rd_chk("cmp_up", MTIMER_CTRL, 32'h7);
    check_eq("int_cmp_up", {56'd0, int_flag_o}, 64'd1);
    wr(MTIMER_CTRL, 32'h1);
    check_eq("ie_clr", {56'd0, int_flag_o}, 64'd0);
    rd_chk("ie_clr_pend", MTIMER_CTRL, 32'h5);
    wr(MTIMER_CTRL, 32'h7);
    check_eq("w1c_int", {56'd0, int_flag_o}, 64'd0);
    rd_chk("w1c_clr", MTIMER_CTRL, 32'h3);
    wr(MTIMER_CTRL, 32'd0);

    // 32-bit rollover and shadowed high word
    wr(MTIMER_MTIME_HI, 32'd0);
    wr(MTIMER_MTIME_LO, 32'hFFFF_FFFF);
    wr(MTIMER_CTRL, 32'h1);
    idle(1);
    rd_chk("roll_lo", MTIMER_MTIME_LO, 32'd0);
    rd_chk("roll_hi", MTIMER_MTIME_HI, 32'd1);

    // 64-bit wrap
    wr(MTIMER_CTRL, 32'd0);
    wr(MTIMER_MTIME_HI, 32'hFFFF_FFFF);
    wr(MTIMER_MTIME_LO, 32'hFFFF_FFFF);
    wr(MTIMER_CTRL, 32'h1);
    idle(1);
    wr(MTIMER_CTRL, 32'd0);
    rd_chk("wrap_lo", MTIMER_MTIME_LO, 32'd0);
    rd_chk("wrap_hi", MTIMER_MTIME_HI, 32'd0);

    // Write in a tick cycle wins
    wr(MTIMER_CTRL, 32'h1);
    wr(MTIMER_MTIME_LO, 32'd100);
    rd_chk("wr_tick", MTIMER_MTIME_LO, 32'd100);
    rd_chk("wr_tick_nx", MTIMER_MTIME_LO, 32'd101);

    // PRESC write mid-count restarts the prescaler
    wr(MTIMER_CTRL, 32'd0);
    wr(MTIMER_MTIME_LO, 32'd0);
    wr(MTIMER_CTRL, 32'h0000_0501);
    idle(2);
    wr(MTIMER_CTRL, 32'h0000_0301);
    idle(2);
    rd_chk("rst_p_3", MTIMER_MTIME_LO, 32'd0);
    rd_chk("rst_p_4", MTIMER_MTIME_LO, 32'd0);
    rd_chk("rst_p_5", MTIMER_MTIME_LO, 32'd1);

    // Reset mid-transfer with interrupt asserted and shadow loaded
    wr(MTIMER_CTRL, 32'd0);
    wr(MTIMER_MTIME_HI, 32'd7);
    wr(MTIMER_CMP_HI, 32'd0);
    wr(MTIMER_CMP_LO, 32'd0);
    wr(MTIMER_CTRL, 32'h3);
    idle(1);
    check_eq("pre_rst_int", {56'd0, int_flag_o}, 64'd1);
    xfer(1'b0, MTIMER_MTIME_LO, 32'd0, scratch);
    req_i = 1'b1; we_i = 1'b0; addr_i = BASE | 32'h4; rst = 1'b0;
    @(posedge clk);
    #1;
    req_i = 1'b0; rst = 1'b1;
    check_eq("mid_rst_ack", {63'd0, ack_o}, 64'd0);
    check_eq("mid_rst_int", {56'd0, int_flag_o}, 64'd0);
    idle(1);
    check_eq("mid_rst_ack2", {63'd0, ack_o}, 64'd0);
    rd_chk("post_shadow", MTIMER_MTIME_HI, 32'd0);
    rd_chk("post_ctrl", MTIMER_CTRL, 32'd0);
    rd_chk("post_lo", MTIMER_MTIME_LO, 32'd0);
    rd_chk("post_hi", MTIMER_MTIME_HI, 32'd0);
    rd_chk("post_cmplo", MTIMER_CMP_LO, 32'hFFFF_FFFF);
    rd_chk("post_cmphi", MTIMER_CMP_HI, 32'hFFFF_FFFF);

    // Unmapped offset: acknowledged, reads zero, writes ignored
    wr(5'h14, 32'hDEAD_BEEF);
    rd_chk("unmapped", 5'h14, 32'd0);
    check_eq("post_int", {56'd0, int_flag_o}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
